serdes_reg: RTL and testbench
=============================

SERDES_REG -- requirements
Module: serdes_reg

Interface
REQ-001 Parameter LEN, default 32: total register width in bits.
REQ-002 Parameter W, default 1: bits shifted per enabled cycle.
REQ-003 Parameter INIT, default 0: LEN-bit reset value of the data register.
REQ-004 Parameter MSB_FIRST, default 0: 0 = shift toward bit 0 (LSB out first), 1 = shift toward bit LEN-1 (MSB out first).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  reset; asynchronous, active-high.
REQ-007 i_load  input  1  parallel load strobe.
REQ-008 i_par  input  LEN  parallel load data.
REQ-009 i_en  input  1  shift enable.
REQ-010 i_d  input  W  serial input bits, shifted in on enabled cycles.
REQ-011 o_q  output  W  serial output bits currently at the exit end.
REQ-012 o_par  output  LEN  full register contents.
REQ-013 o_busy  output  1  high while a loaded word still has steps remaining.
REQ-014 o_done  output  1  one-cycle pulse after the final step of a loaded word.

Function
REQ-015 Elaboration SHALL fail unless LEN mod W == 0 and LEN >= 2*W.
REQ-016 Step counter cnt: width clog2(LEN/W + 1); range 0..LEN/W.
REQ-017 MSB_FIRST=0: o_q = data[W-1:0]; shift = data <= {i_d, data[LEN-1:W]}.
REQ-018 MSB_FIRST=1: o_q = data[LEN-1:LEN-W]; shift = data <= {data[LEN-W-1:0], i_d}.
REQ-019 o_par = data, combinational, no added latency.
REQ-020 i_load=1: data <= i_par, cnt <= LEN/W, o_done <= 0; no shift that cycle.
REQ-021 i_load=1 and i_en=1 in the same cycle: load wins; i_en ignored.
REQ-022 i_en=1, i_load=0, cnt>0: shift per REQ-017/018; cnt <= cnt-1.
REQ-023 i_en=1, i_load=0, cnt==1: o_done <= 1 in addition to REQ-022.
REQ-024 i_en=1, i_load=0, cnt==0: free-running mode; data still shifts; cnt stays 0; o_done <= 0.
REQ-025 i_en=0, i_load=0: data and cnt hold; o_done <= 0.
REQ-026 o_done registered; high for exactly one cycle per completed word; never asserted without a preceding load.
REQ-027 o_busy = (cnt != 0), combinational from cnt.
REQ-028 Load while busy: restarts the word; previous word abandoned; no o_done for it.
REQ-029 Stalls (i_en=0) mid-word: cnt and data hold; final step still produces o_done.

Reset
REQ-030 i_rst=1 SHALL immediately, without a clock edge, set data=INIT, cnt=0, o_done=0, o_busy=0.
REQ-031 While i_rst=1, i_load and i_en SHALL be ignored.
REQ-032 Reset mid-word: word abandoned; no o_done generated after release.
REQ-033 First update after release: first rising clk edge with i_rst=0.

Verification
REQ-034 LEN=8, W=1, MSB_FIRST=0: load 0xA5, then 8 cycles i_en=1, i_d=0 -> o_q sequence 1,0,1,0,0,1,0,1; o_busy high for 8 cycles; o_done high in cycle 9 only; o_par=0x00 afterward.
REQ-035 LEN=8, W=4, MSB_FIRST=1: load 0x3C, 2 cycles i_en=1, i_d=0xF -> o_q 0x3 then 0xC; o_par=0xFF; o_done pulses once.
REQ-036 LEN=8, W=1: load 0x01, i_en pattern 1,0,0,1,... (8 enabled steps with stalls) -> cnt holds during stalls; o_done exactly one cycle after 8th enabled step.
REQ-037 LEN=8, W=1: load 0xFF, 3 steps, then i_load=1 with i_en=1 and i_par=0x0F -> no shift, o_par=0x0F, cnt=8; no o_done for the first word.
REQ-038 INIT=0x5A, LEN=8: load 0x00, 4 steps, assert i_rst between clock edges -> o_par=0x5A and o_busy=0 before the next edge; no o_done after release.
REQ-039 No load since reset, i_en=1 for 10 cycles, i_d=1 -> data shifts in ones (o_par=0xFF after 8 cycles); o_busy and o_done stay 0.

Source files
------------

// File: rtl/serdes_reg.sv
// serdes_reg: parallel-load shift register with word step counter, busy and done pulse
module serdes_reg #(
   parameter int             LEN       = 32,
   parameter int             W         = 1,
   parameter logic [LEN-1:0] INIT      = '0,
   parameter bit             MSB_FIRST = 1'b0
) (
   input  logic           clk,
   input  logic           i_rst,
   input  logic           i_load,
   input  logic [LEN-1:0] i_par,
   input  logic           i_en,
   input  logic [W-1:0]   i_d,
   output logic [W-1:0]   o_q,
   output logic [LEN-1:0] o_par,
   output logic           o_busy,
   output logic           o_done
);
   localparam int STEPS = LEN / W;
   localparam int CW    = $clog2(STEPS + 1);

   logic [LEN-1:0] data;
   logic [LEN-1:0] shifted;
   logic [CW-1:0]  cnt;

   if ((LEN % W) != 0 || LEN < 2 * W) begin : g_bad_params
      $error("serdes_reg: LEN must be a multiple of W and at least 2*W");
   end

   if (MSB_FIRST) begin : g_msb
      assign o_q     = data[LEN-1 -: W];
      assign shifted = {data[LEN-W-1:0], i_d};
   end else begin : g_lsb
      assign o_q     = data[W-1:0];
      assign shifted = {i_d, data[LEN-1:W]};
   end

   assign o_par  = data;
   assign o_busy = cnt != '0;

   // load restarts a word, enabled cycles shift and count down, done pulses after the last step
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         data   <= INIT;
         cnt    <= '0;
         o_done <= 1'b0;
      end else if (i_load) begin
         data   <= i_par;
         cnt    <= CW'(STEPS);
         o_done <= 1'b0;
      end else if (i_en) begin
         data   <= shifted;
         cnt    <= o_busy ? cnt - 1'b1 : '0;
         o_done <= cnt == CW'(1);
      end else begin
         o_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_serdes_reg.sv
// tb_serdes_reg: checks three serdes_reg configurations against an arithmetic word model
module tb_serdes_reg;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic        en = 1'b0;
   logic [63:0] par = '0;
   logic [63:0] d = '0;
   logic        go = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   logic [7:0]  q0;
   logic [3:0]  q1;
   logic [2:0]  q2;
   logic [7:0]  p0, p1;
   logic [11:0] p2;
   logic [2:0]  busy, done;

   int          ln   [3] = '{8, 8, 12};
   int          wd   [3] = '{1, 4, 3};
   bit          msb  [3] = '{1'b0, 1'b1, 1'b0};
   logic [63:0] init [3] = '{64'h5A, 64'h00, 64'hC35};

   logic [63:0] m_data [3];
   int          m_cnt  [3];
   bit          m_done [3];
   logic [63:0] q_a    [3];
   logic [63:0] par_a  [3];

   always #5 clk = ~clk;

   serdes_reg #(.LEN(8), .W(1), .INIT(8'h5A), .MSB_FIRST(1'b0)) u0 (
      .clk(clk), .i_rst(rst), .i_load(load), .i_par(par[7:0]), .i_en(en), .i_d(d[0:0]),
      .o_q(q0), .o_par(p0), .o_busy(busy[0]), .o_done(done[0]));
   serdes_reg #(.LEN(8), .W(4), .INIT(8'h00), .MSB_FIRST(1'b1)) u1 (
      .clk(clk), .i_rst(rst), .i_load(load), .i_par(par[7:0]), .i_en(en), .i_d(d[3:0]),
      .o_q(q1), .o_par(p1), .o_busy(busy[1]), .o_done(done[1]));
   serdes_reg #(.LEN(12), .W(3), .INIT(12'hC35), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .i_rst(rst), .i_load(load), .i_par(par[11:0]), .i_en(en), .i_d(d[2:0]),
      .o_q(q2), .o_par(p2), .o_busy(busy[2]), .o_done(done[2]));

   assign q_a[0] = 64'(q0);
   assign q_a[1] = 64'(q1);
   assign q_a[2] = 64'(q2);
   assign par_a[0] = 64'(p0);
   assign par_a[1] = 64'(p1);
   assign par_a[2] = 64'(p2);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // word model: register as a number, shifting by multiplying/dividing by 2^w
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         logic [63:0] mask, dk;
         mask = (64'd1 << ln[k]) - 64'd1;
         dk   = d & ((64'd1 << wd[k]) - 64'd1);
         if (rst) begin
            m_data[k] = init[k];
            m_cnt[k]  = 0;
            m_done[k] = 1'b0;
         end else if (load) begin
            m_data[k] = par & mask;
            m_cnt[k]  = ln[k] / wd[k];
            m_done[k] = 1'b0;
         end else if (en) begin
            m_data[k] = msb[k] ? ((m_data[k] << wd[k]) | dk) & mask
                               : (m_data[k] >> wd[k]) | (dk << (ln[k] - wd[k]));
            m_done[k] = m_cnt[k] == 1;
            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
         end else begin
            m_done[k] = 1'b0;
         end
      end
   end

   // every cycle: all outputs of all instances against the model
   always @(negedge clk) begin
      if (go) begin
         for (int k = 0; k < 3; k++) begin
            logic [63:0] wm, eq;
            wm = (64'd1 << wd[k]) - 64'd1;
            eq = msb[k] ? (m_data[k] >> (ln[k] - wd[k])) & wm : m_data[k] & wm;
            chk($sformatf("u%0d o_q", k), q_a[k], eq);
            chk($sformatf("u%0d o_par", k), par_a[k], m_data[k]);
            chk($sformatf("u%0d o_busy", k), 64'(busy[k]), 64'(m_cnt[k] != 0));
            chk($sformatf("u%0d o_done", k), 64'(done[k]), 64'(m_done[k]));
         end
      end
   end

   initial begin
      logic [7:0] a5;
      int steps;
      #1 rst = 1'b1;
      load = 1'b1;
      en = 1'b1;
      tick();
      go = 1'b1;
      tick();
      chk("reset u0 o_par", 64'(p0), 64'h5A);
      chk("reset u1 o_par", 64'(p1), 64'h00);
      chk("reset u2 o_par", 64'(p2), 64'hC35);
      chk("reset busy", 64'(busy), 64'h0);
      rst = 1'b0;
      load = 1'b0;
      // free running with no load: ones shift in, no busy, no done
      d = '1;
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("freerun done", 64'(done), 64'h0);
         if (i == 7) chk("freerun u0 o_par", 64'(p0), 64'hFF);
      end
      chk("freerun u1 o_par", 64'(p1), 64'hFF);
      // LSB-first serialisation of 0xA5
      load = 1'b1;
      par = 64'hA5;
      en = 1'b0;
      tick();
      load = 1'b0;
      a5 = 8'hA5;
      d = '0;
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("A5 u0 o_q", 64'(q0), 64'(a5[i]));
         chk("A5 u0 busy", 64'(busy[0]), 64'h1);
         chk("A5 u0 done early", 64'(done[0]), 64'h0);
         tick();
      end
      chk("A5 u0 done", 64'(done[0]), 64'h1);
      chk("A5 u0 o_par", 64'(p0), 64'h00);
      chk("A5 u0 idle", 64'(busy[0]), 64'h0);
      en = 1'b0;
      tick();
      chk("A5 u0 done once", 64'(done[0]), 64'h0);
      // MSB-first nibbles of 0x3C with 0xF shifted in
      load = 1'b1;
      par = 64'h3C;
      tick();
      load = 1'b0;
      chk("3C u1 o_q hi", 64'(q1), 64'h3);
      en = 1'b1;
      d = 64'hF;
      tick();
      chk("3C u1 o_q lo", 64'(q1), 64'hC);
      tick();
      chk("3C u1 o_par", 64'(p1), 64'hFF);
      chk("3C u1 done", 64'(done[1]), 64'h1);
      en = 1'b0;
      tick();
      chk("3C u1 done once", 64'(done[1]), 64'h0);
      // stalls mid-word
      load = 1'b1;
      par = 64'h01;
      tick();
      load = 1'b0;
      steps = 0;
      while (steps < 8) begin
         en = (steps % 3 == 0) ? 1'b1 : 1'($urandom_range(1));
         if (en) steps++;
         tick();
         if (steps < 8) chk("stall u0 done", 64'(done[0]), 64'h0);
         if (steps < 8) chk("stall u0 busy", 64'(busy[0]), 64'h1);
      end
      chk("stall u0 done", 64'(done[0]), 64'h1);
      en = 1'b0;
      tick();
      // reload while busy
      load = 1'b1;
      par = 64'hFF;
      tick();
      load = 1'b0;
      en = 1'b1;
      repeat (3) tick();
      load = 1'b1;
      par = 64'h0F;
      tick();
      load = 1'b0;
      chk("reload u0 o_par", 64'(p0), 64'h0F);
      chk("reload u0 busy", 64'(busy[0]), 64'h1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("reload u0 done early", 64'(done[0]), 64'h0);
      end
      tick();
      chk("reload u0 done", 64'(done[0]), 64'h1);
      // asynchronous reset mid-word
      load = 1'b1;
      par = 64'h00;
      en = 1'b0;
      tick();
      load = 1'b0;
      en = 1'b1;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      chk("async u0 o_par", 64'(p0), 64'h5A);
      chk("async busy", 64'(busy), 64'h0);
      load = 1'b1;
      par = 64'h33;
      tick();
      chk("held u0 o_par", 64'(p0), 64'h5A);
      rst = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post reset done", 64'(done), 64'h0);
      end
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst  = $urandom_range(99) == 0;
         load = $urandom_range(7) == 0;
         en   = $urandom_range(3) != 0;
         par  = {$urandom, $urandom};
         d    = 64'($urandom);
         tick();
      end
      rst = 1'b0;
      load = 1'b0;
      en = 1'b0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
